action_table: RTL and testbench

- Storage and lookup end of the action-table programming interface: it consumes the entry-write and default-write strobes produced by the action MMIO register block.
- Serves a one-cycle-latency action lookup for the match stage of the packet pipeline.
- On a match hit to a programmed entry it returns that entry's action. On a miss, or a hit to an unprogrammed entry, it returns the default action.
- Keeps saturating hit/miss statistics.

---
 rtl/action_table_if.sv | 48 ++++
 rtl/action_table.sv | 113 +++++++++++
 tb/tb_action_table.sv | 227 ++++++++++++++++++++++
 3 files changed

// File: rtl/action_table_if.sv
`default_nettype none
// +--------------------------------------------------------------------+
// | action_table_if : programming strobes, lookup request and result   |
// | Revision 1.0                                                       |
// +--------------------------------------------------------------------+
interface action_table_if #(
   parameter int ENTRIES  = 16,
   parameter int ACTION_W = 64,
   parameter int IDX_W    = $clog2(ENTRIES),
   parameter int TAG_W    = 8
);
   logic                action_wr_en;
   logic [IDX_W-1:0]    action_wr_addr;
   logic [ACTION_W-1:0] action_wr_data;
   logic                action_wr_default;
   logic [ACTION_W-1:0] action_default_data;

   logic                lkp_valid;
   logic                lkp_ready;
   logic                lkp_hit;
   logic [IDX_W-1:0]    lkp_idx;
   logic [TAG_W-1:0]    lkp_tag;

   logic                act_valid;
   logic                act_ready;
   logic [ACTION_W-1:0] act_data;
   logic                act_hit;
   logic [TAG_W-1:0]    act_tag;

   modport master (
      output action_wr_en, action_wr_addr, action_wr_data,
      output action_wr_default, action_default_data,
      output lkp_valid, lkp_hit, lkp_idx, lkp_tag,
      input  lkp_ready,
      input  act_valid, act_data, act_hit, act_tag,
      output act_ready
   );

   modport slave (
      input  action_wr_en, action_wr_addr, action_wr_data,
      input  action_wr_default, action_default_data,
      input  lkp_valid, lkp_hit, lkp_idx, lkp_tag,
      output lkp_ready,
      output act_valid, act_data, act_hit, act_tag,
      input  act_ready
   );
endinterface
`default_nettype wire

// File: rtl/action_table.sv
`default_nettype none
// +--------------------------------------------------------------------+
// | action_table : programmable action storage with 1-cycle lookup,    |
// | write-first bypass and saturating hit/miss counters                |
// | Revision 1.0                                                       |
// +--------------------------------------------------------------------+
module action_table #(
   parameter int ENTRIES  = 16,
   parameter int ACTION_W = 64,
   parameter int IDX_W    = $clog2(ENTRIES),
   parameter int TAG_W    = 8
) (
   input  wire logic     clk,
   input  wire logic     resetn,
   action_table_if.slave bus,
   output logic [31:0]   hit_count,
   output logic [31:0]   miss_count
);
   localparam logic [IDX_W:0] ENTRIES_L = ENTRIES[IDX_W:0];

   logic [ACTION_W-1:0] entry_q [ENTRIES];
   logic [ACTION_W-1:0] entry_d [ENTRIES];
   logic [ENTRIES-1:0]  valid_q, valid_d;
   logic [ACTION_W-1:0] default_q, default_d;
   logic                act_valid_q, act_valid_d;
   logic [ACTION_W-1:0] act_data_q, act_data_d;
   logic                act_hit_q, act_hit_d;
   logic [TAG_W-1:0]    act_tag_q, act_tag_d;
   logic [31:0]         hit_count_q, hit_count_d;
   logic [31:0]         miss_count_q, miss_count_d;

   logic                lkp_ready;
   logic                accept;
   logic                wr_in_range;
   logic                lkp_in_range;
   logic                res_hit;
   logic [ACTION_W-1:0] res_data;

   always_comb begin
      lkp_ready    = !act_valid_q || bus.act_ready;
      accept       = bus.lkp_valid && lkp_ready;
      wr_in_range  = {1'b0, bus.action_wr_addr} < ENTRIES_L;
      lkp_in_range = {1'b0, bus.lkp_idx} < ENTRIES_L;

      entry_d = entry_q;
      valid_d = valid_q;
      if (bus.action_wr_en && wr_in_range) begin
         entry_d[bus.action_wr_addr] = bus.action_wr_data;
         valid_d[bus.action_wr_addr] = 1'b1;
      end
      default_d = bus.action_wr_default ? bus.action_default_data : default_q;

      // Resolving against the next-state copies gives write-first bypass for free.
      res_hit  = bus.lkp_hit && lkp_in_range && valid_d[bus.lkp_idx];
      res_data = res_hit ? entry_d[bus.lkp_idx] : default_d;

      act_valid_d = act_valid_q;
      act_data_d  = act_data_q;
      act_hit_d   = act_hit_q;
      act_tag_d   = act_tag_q;
      if (accept) begin
         act_valid_d = 1'b1;
         act_data_d  = res_data;
         act_hit_d   = res_hit;
         act_tag_d   = bus.lkp_tag;
      end else if (act_valid_q && bus.act_ready) begin
         act_valid_d = 1'b0;
      end

      hit_count_d  = hit_count_q;
      miss_count_d = miss_count_q;
      if (accept) begin
         if (res_hit) begin
            if (hit_count_q != 32'hFFFF_FFFF) hit_count_d = hit_count_q + 32'd1;
         end else begin
            if (miss_count_q != 32'hFFFF_FFFF) miss_count_d = miss_count_q + 32'd1;
         end
      end
   end

   always_ff @(posedge clk or negedge resetn) begin
      if (!resetn) begin
         for (int i = 0; i < ENTRIES; i++) entry_q[i] <= '0;
         valid_q      <= '0;
         default_q    <= '0;
         act_valid_q  <= 1'b0;
         act_data_q   <= '0;
         act_hit_q    <= 1'b0;
         act_tag_q    <= '0;
         hit_count_q  <= '0;
         miss_count_q <= '0;
      end else begin
         entry_q      <= entry_d;
         valid_q      <= valid_d;
         default_q    <= default_d;
         act_valid_q  <= act_valid_d;
         act_data_q   <= act_data_d;
         act_hit_q    <= act_hit_d;
         act_tag_q    <= act_tag_d;
         hit_count_q  <= hit_count_d;
         miss_count_q <= miss_count_d;
      end
   end

   assign bus.lkp_ready = lkp_ready;
   assign bus.act_valid = act_valid_q;
   assign bus.act_data  = act_data_q;
   assign bus.act_hit   = act_hit_q;
   assign bus.act_tag   = act_tag_q;
   assign hit_count     = hit_count_q;
   assign miss_count    = miss_count_q;
endmodule
`default_nettype wire

// File: tb/tb_action_table.sv
`default_nettype none
// +--------------------------------------------------------------------+
// | tb_action_table : directed scoreboard bench for action_table       |
// | Revision 1.0                                                       |
// +--------------------------------------------------------------------+
module tb_action_table;
   localparam int ENTRIES  = 16;
   localparam int ACTION_W = 64;
   localparam int IDX_W    = 4;
   localparam int TAG_W    = 8;

   logic        clk = 1'b0;
   logic        resetn = 1'b0;
   logic [31:0] hit_count, miss_count;

   always #5 clk = ~clk;

   action_table_if #(.ENTRIES(ENTRIES), .ACTION_W(ACTION_W), .IDX_W(IDX_W), .TAG_W(TAG_W)) bus ();

   action_table #(.ENTRIES(ENTRIES), .ACTION_W(ACTION_W), .IDX_W(IDX_W), .TAG_W(TAG_W)) dut (
      .clk        (clk),
      .resetn     (resetn),
      .bus        (bus.slave),
      .hit_count  (hit_count),
      .miss_count (miss_count)
   );

   typedef struct packed {
      logic [ACTION_W-1:0] data;
      logic                hit;
      logic [TAG_W-1:0]    tag;
   } res_t;

   res_t                sb[$];
   logic [ACTION_W-1:0] m_tbl [ENTRIES];
   logic                m_vld [ENTRIES];
   logic [ACTION_W-1:0] m_def;
   logic [31:0]         m_hits, m_miss;
   int                  errors = 0;
   int                  checks = 0;

   task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
      end
   endtask

   task automatic model_reset();
      for (int i = 0; i < ENTRIES; i++) begin
         m_tbl[i] = '0;
         m_vld[i] = 1'b0;
      end
      m_def  = '0;
      m_hits = '0;
      m_miss = '0;
      sb.delete();
   endtask

   task automatic idle();
      bus.action_wr_en        = 1'b0;
      bus.action_wr_addr      = '0;
      bus.action_wr_data      = '0;
      bus.action_wr_default   = 1'b0;
      bus.action_default_data = '0;
      bus.lkp_valid           = 1'b0;
      bus.lkp_hit             = 1'b0;
      bus.lkp_idx             = '0;
      bus.lkp_tag             = '0;
      bus.act_ready           = 1'b1;
   endtask

   task automatic lookup(input logic hit, input logic [IDX_W-1:0] idx, input logic [TAG_W-1:0] tag);
      bus.lkp_valid = 1'b1;
      bus.lkp_hit   = hit;
      bus.lkp_idx   = idx;
      bus.lkp_tag   = tag;
   endtask

   // One clock cycle: check the visible output against the scoreboard,
   // predict this cycle's acceptance, advance the clock, check counters.
   task automatic step();
      logic   exp_ready, acc, rhit;
      logic [ACTION_W-1:0] row, dflt;
      res_t   e;
      #1;
      exp_ready = (sb.size() == 0) || bus.act_ready;
      acc       = bus.lkp_valid && exp_ready;
      chk("act_valid", 64'(bus.act_valid), 64'(sb.size() != 0));
      chk("lkp_ready", 64'(bus.lkp_ready), 64'(exp_ready));
      if (sb.size() != 0) begin
         chk("act_data", bus.act_data, sb[0].data);
         chk("act_hit", 64'(bus.act_hit), 64'(sb[0].hit));
         chk("act_tag", 64'(bus.act_tag), 64'(sb[0].tag));
         if (bus.act_ready) void'(sb.pop_front());
      end
      if (bus.action_wr_en) begin
         m_tbl[bus.action_wr_addr] = bus.action_wr_data;
         m_vld[bus.action_wr_addr] = 1'b1;
      end
      if (bus.action_wr_default) m_def = bus.action_default_data;
      if (acc) begin
         row  = m_tbl[bus.lkp_idx];
         dflt = m_def;
         rhit = bus.lkp_hit && m_vld[bus.lkp_idx];
         e.data = rhit ? row : dflt;
         e.hit  = rhit;
         e.tag  = bus.lkp_tag;
         sb.push_back(e);
         if (rhit) begin
            if (m_hits != 32'hFFFF_FFFF) m_hits = m_hits + 1;
         end else begin
            if (m_miss != 32'hFFFF_FFFF) m_miss = m_miss + 1;
         end
      end
      @(posedge clk);
      @(negedge clk);
      chk("hit_count", 64'(hit_count), 64'(m_hits));
      chk("miss_count", 64'(miss_count), 64'(m_miss));
   endtask

   initial begin
      idle();
      model_reset();
      repeat (2) @(negedge clk);
      #1;
      chk("rst_act_valid", 64'(bus.act_valid), 64'd0);
      chk("rst_lkp_ready", 64'(bus.lkp_ready), 64'd1);
      chk("rst_act_data", bus.act_data, 64'd0);
      chk("rst_hit_count", 64'(hit_count), 64'd0);
      chk("rst_miss_count", 64'(miss_count), 64'd0);
      @(negedge clk);
      resetn = 1'b1;
      @(negedge clk);

      // Lookup into an empty table resolves to the reset default.
      lookup(1'b1, 4'd3, 8'h5A);
      step();
      idle();
      step();

      // Program entry 3 and the default, then hit and miss.
      bus.action_wr_en        = 1'b1;
      bus.action_wr_addr      = 4'd3;
      bus.action_wr_data      = 64'h1122_3344_5566_7788;
      bus.action_wr_default   = 1'b1;
      bus.action_default_data = 64'hDEAD_BEEF_0000_0001;
      step();
      idle();
      lookup(1'b1, 4'd3, 8'h01);
      step();
      lookup(1'b0, 4'd7, 8'h02);
      step();
      lookup(1'b1, 4'd9, 8'h03);
      step();
      idle();
      step();

      // Write-first bypass for entry and default.
      bus.action_wr_en   = 1'b1;
      bus.action_wr_addr = 4'd5;
      bus.action_wr_data = 64'hAAAA;
      lookup(1'b1, 4'd5, 8'h04);
      step();
      bus.action_wr_en        = 1'b0;
      bus.action_wr_default   = 1'b1;
      bus.action_default_data = 64'hBBBB;
      lookup(1'b0, 4'd5, 8'h05);
      step();
      idle();
      step();

      // Backpressure: output held, request stalled, then drained in order.
      bus.act_ready = 1'b0;
      lookup(1'b1, 4'd3, 8'h01);
      step();
      lookup(1'b1, 4'd5, 8'h02);
      repeat (3) step();
      bus.act_ready = 1'b1;
      step();
      lookup(1'b0, 4'd0, 8'h03);
      step();
      bus.lkp_valid = 1'b0;
      step();
      step();

      // Miss counter saturation.
      idle();
      force dut.miss_count_q = 32'hFFFF_FFFE;
      @(posedge clk);
      @(negedge clk);
      release dut.miss_count_q;
      m_miss = 32'hFFFF_FFFE;
      for (int i = 0; i < 3; i++) begin
         lookup(1'b0, 4'd1, 8'(8'h10 + i));
         step();
      end
      idle();
      step();
      step();

      // Asynchronous reset while a result is pending.
      bus.act_ready = 1'b0;
      lookup(1'b1, 4'd3, 8'h77);
      step();
      idle();
      bus.act_ready = 1'b0;
      #2;
      resetn = 1'b0;
      #1;
      chk("async_rst_act_valid", 64'(bus.act_valid), 64'd0);
      model_reset();
      @(negedge clk);
      resetn = 1'b1;
      idle();
      @(negedge clk);
      lookup(1'b1, 4'd3, 8'h78);
      step();
      idle();
      step();

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end
endmodule
`default_nettype wire
